// File: rtl/ad_bus_initiator.sv
// ad_bus_initiator
//   Single-outstanding initiator for a multiplexed address/data bus.
//   Each accepted host request runs ADDR (ale, address driven), an optional
//   TURN cycle for reads (bus released before the responder drives it),
//   DATA (rd/wr strobe, waits for rdy with a cycle limit) and a one-cycle
//   RESP pulse back to the host.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid/req_ready host request handshake (ready only in IDLE)
//   req_write/addr/wdata request fields, captured on accept
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata/rsp_err   read data / timeout flag, held until the next RESP
//   err_count           saturating count of timed-out transfers
//   ad_out/ad_oe/ad_in  bus drive value, drive enable, sampled bus value
//   ale, rd, wr         address latch enable and data-phase strobes
//   rdy                 responder ready, looked at only in DATA
module ad_bus_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  err_count,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  input  logic [31:0] ad_in,
  output logic        ale,
  output logic        rd,
  output logic        wr,
  input  logic        rdy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_TURN = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Last DATA cycle index on which a missing rdy ends the transfer.
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_write;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_ecnt;
  logic [7:0]  r_cnt;

  // Only the low half of the bus carries read data.
  logic w_unused_ad_hi;
  assign w_unused_ad_hi = ^ad_in[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ecnt  <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_cnt   <= '0;
          r_state <= r_write ? S_DATA : S_TURN;
        end
        S_TURN: r_state <= S_DATA;
        S_DATA: begin
          if (rdy) begin
            // Write completions leave the last read data untouched.
            if (!r_write) r_rdata <= ad_in[15:0];
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == LP_LAST) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            if (r_ecnt != 8'hFF) r_ecnt <= r_ecnt + 8'd1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode: bus and handshake outputs follow the state register
  // alone, so an asynchronous reset drops the strobes and releases the bus
  // without waiting for a clock edge.
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign ale       = (r_state == S_ADDR);
  assign rd        = (r_state == S_DATA) && !r_write;
  assign wr        = (r_state == S_DATA) &&  r_write;
  assign ad_oe     = (r_state == S_ADDR) || ((r_state == S_DATA) && r_write);
  assign ad_out    = (r_state == S_ADDR) ? r_addr :
                     ((r_state == S_DATA) && r_write) ? {16'h0000, r_wdata} :
                     32'h0000_0000;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign err_count = r_ecnt;

endmodule

// File: tb/tb_ad_bus_initiator.sv
// Bench for ad_bus_initiator: transaction-level model expands each accepted
// request into its expected per-cycle bus picture; one process compares the
// DUT against it every cycle and also drives rdy from the same picture.
module tb_ad_bus_initiator;
  localparam int TO = 16;

  logic        clk, reset_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [7:0]  err_count;
  logic [31:0] ad_out, ad_in;
  logic        ad_oe, ale, rd, wr, rdy;

  ad_bus_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .ale(ale), .rd(rd), .wr(wr), .rdy(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready, vld, ale, oe, rd, wr, err;
    logic [31:0] out;
    logic [15:0] rdata;
    logic [7:0]  ecnt;
    logic        drv_rdy;
  } exp_t;

  exp_t        q[$];
  logic [15:0] h_rdata;
  logic        h_err;
  logic [7:0]  h_ecnt;
  int          rdy_cfg;
  int          n_chk, n_fail;
  int          n_ale, n_rd, n_wr, n_vld, n_gap;
  logic [31:0] ale_out, wr_out;

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    e.rdata = h_rdata;
    e.err   = h_err;
    e.ecnt  = h_ecnt;
    return e;
  endfunction

  // Expand one request: ro = DATA cycle (1-based) on which rdy rises, 0 = never.
  task automatic build(input logic w, input logic [31:0] a, input logic [15:0] d,
                       input int ro, input logic [15:0] din);
    exp_t base, e;
    logic to;
    int   n;
    to = !(ro >= 1 && ro <= TO);
    n  = to ? TO : ro;
    base = '0;
    base.rdata = h_rdata;
    base.err   = h_err;
    base.ecnt  = h_ecnt;
    e = base; e.ale = 1; e.oe = 1; e.out = a; e.drv_rdy = (ro == 1);
    q.push_back(e);
    if (!w) begin
      e = base; e.drv_rdy = (ro == 1);
      q.push_back(e);
    end
    for (int j = 1; j <= n; j++) begin
      e = base;
      if (w) begin e.oe = 1; e.wr = 1; e.out = {16'h0000, d}; end
      else e.rd = 1;
      e.drv_rdy = (ro != 0) && (j >= ro);
      q.push_back(e);
    end
    e = base;
    e.vld   = 1;
    e.err   = to;
    e.rdata = to ? 16'h0000 : (w ? h_rdata : din);
    e.ecnt  = to ? ((h_ecnt == 8'hFF) ? 8'hFF : h_ecnt + 8'd1) : h_ecnt;
    q.push_back(e);
  endtask

  // Model advance: one expected cycle consumed per edge, accept when empty.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      h_rdata = '0; h_err = 1'b0; h_ecnt = '0;
    end else if (q.size() != 0) begin
      if (q[0].vld) begin h_rdata = q[0].rdata; h_err = q[0].err; h_ecnt = q[0].ecnt; end
      void'(q.pop_front());
    end else if (req_valid) begin
      build(req_write, req_addr, req_wdata, rdy_cfg, ad_in[15:0]);
    end
  end

  // Per-cycle compare on the falling edge; also drives rdy.
  always @(negedge clk) begin
    exp_t        e;
    logic [62:0] act, expv;
    e    = (q.size() != 0) ? q[0] : idle_e();
    act  = {req_ready, rsp_valid, ale, ad_oe, rd, wr, rsp_err, ad_out, rsp_rdata, err_count};
    expv = e[63:1];
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL cycle t=%0t act={rdy_r,vld,ale,oe,rd,wr,err,out,rdata,ecnt}=%h exp=%h",
               $time, act, expv);
    end
    rdy = e.drv_rdy;
    if (ale) begin n_ale++; ale_out = ad_out; end
    if (wr) begin n_wr++; wr_out = ad_out; end
    if (rd) n_rd++;
    if (rsp_valid) n_vld++;
    if (!req_ready && !ale && !rd && !wr && !ad_oe && !rsp_valid) n_gap++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic clr();
    n_ale = 0; n_rd = 0; n_wr = 0; n_vld = 0; n_gap = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=busy expected=idle");
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [15:0] d, input int ro);
    @(negedge clk);
    clr();
    req_write = w; req_addr = a; req_wdata = d; rdy_cfg = ro; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; clr();
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; ad_in = '0; rdy_cfg = 0;
    #3;
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_bus", {ad_out[29:0], ad_oe, ale}, 32'd0);
    chk("reset_strobes", {27'd0, rd, wr, rsp_valid, rsp_err, 1'b0}, 32'd0);
    chk("reset_ecnt", {24'd0, err_count}, 32'd0);
    @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;

    // Write, rdy high throughout.
    issue(1'b1, 32'h0000_1234, 16'hBEEF, 1);
    chk("wr_ale_cycles", n_ale, 1);
    chk("wr_ale_out", ale_out, 32'h0000_1234);
    chk("wr_wr_cycles", n_wr, 1);
    chk("wr_data_out", wr_out, 32'h0000_BEEF);
    chk("wr_rsp_cnt", n_vld, 1);
    chk("wr_rsp_err", {31'd0, rsp_err}, 0);

    // Read, rdy on third DATA cycle.
    ad_in = 32'hFFFF_A5A5;
    issue(1'b0, 32'h0000_0100, 16'h0000, 3);
    chk("rd_turn_cycles", n_gap, 1);
    chk("rd_rd_cycles", n_rd, 3);
    chk("rd_rdata", {16'd0, rsp_rdata}, 32'h0000_A5A5);
    chk("rd_err", {31'd0, rsp_err}, 0);

    // Read timeout.
    ad_in = 32'h0000_1111;
    issue(1'b0, 32'h0000_0200, 16'h0000, 0);
    chk("to_rd_cycles", n_rd, TO);
    chk("to_err", {31'd0, rsp_err}, 1);
    chk("to_rdata", {16'd0, rsp_rdata}, 0);
    chk("to_ecnt", {24'd0, err_count}, 1);

    // rdy on the last permitted DATA cycle still succeeds; one later times out.
    ad_in = 32'h0000_5A5A;
    issue(1'b0, 32'h0000_0300, 16'h0000, TO);
    chk("edge_ok_rdata", {16'd0, rsp_rdata}, 32'h0000_5A5A);
    chk("edge_ok_ecnt", {24'd0, err_count}, 1);
    issue(1'b0, 32'h0000_0300, 16'h0000, TO + 1);
    chk("edge_to_err", {31'd0, rsp_err}, 1);
    chk("edge_to_ecnt", {24'd0, err_count}, 2);

    // Saturation: 2 + 260 timeouts clamps at 255.
    for (int k = 0; k < 260; k++) issue(1'b0, 32'h0000_0400, 16'h0000, 0);
    chk("sat_ecnt", {24'd0, err_count}, 255);

    // Reset during write DATA phase.
    @(negedge clk);
    clr();
    req_write = 1'b1; req_addr = 32'h0000_0500; req_wdata = 16'h1357; rdy_cfg = 0;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_wr", {31'd0, wr}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_oe", {31'd0, ad_oe}, 0);
    chk("rst_async_wr", {31'd0, wr}, 0);
    chk("rst_async_ready", {31'd0, req_ready}, 1);
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_post_ready", {31'd0, req_ready}, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_rsp", n_vld, 0);
    chk("rst_ecnt", {24'd0, err_count}, 0);

    // req_valid held high: a new accept only after each IDLE.
    @(negedge clk);
    clr();
    req_write = 1'b1; req_addr = 32'h0000_0600; req_wdata = 16'h2468; rdy_cfg = 1;
    req_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
    chk("b2b_rsp_cnt", n_vld, 5);
    chk("b2b_ale_cnt", n_ale, 5);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
